mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Multicycle load/store sequencer between the CPU datapath and a synchronous data memory with fixed read latency. Loads: fetches the aligned memory word, then extracts and sign- or zero-extends a byte, halfword, word or doubleword (64-bit build only). Stores: sub-word stores use read-modify-write; aligned full-width stores write directly. Replaces the purely combinational load-size selection with sequencing, misalignment detection and store merging.

Parameters:
DATA_W, 32, memory/register data width; legal values 32 or 64
ADDR_W, 32, byte address width
MEM_LAT, 1, memory read latency in cycles (>=1); mem_rdata valid MEM_LAT cycles after mem_addr is presented

Ports:
clk  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-high
start  in  1  request strobe; accepted only when busy=0
is_store  in  1  1=store, 0=load
size  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when DATA_W=64)
sign_ext  in  1  loads: 1 sign-extend, 0 zero-extend; ignored for stores
addr  in  ADDR_W  byte address
wdata  in  DATA_W  store data, right-justified
mem_addr  out  ADDR_W  aligned word address (low log2(DATA_W/8) bits zero)
mem_wr  out  1  memory write enable
mem_wdata  out  DATA_W  merged write word
mem_rdata  in  DATA_W  memory read data
rdata_out  out  DATA_W  extended load result
busy  out  1  high from the cycle after accept through the DONE cycle
done  out  1  one-cycle completion pulse
misalign  out  1  valid with done; 1 = request rejected

Behaviour:
- Reset: state IDLE; mem_addr, mem_wr, mem_wdata, rdata_out, busy, done, misalign all 0; latency counter 0. Reset overrides any state (mid-operation included); no mem_wr pulse may follow a reset edge.
- Little-endian: byte k of a word = bits [8k+7:8k]; OFF = addr low log2(DATA_W/8) bits.
- Misaligned: half with OFF[0]=1, word with OFF[1:0]!=0, dword with OFF!=0, size=11 when DATA_W=32. Effect: IDLE->DONE, misalign=1, no memory access, rdata_out unchanged.
- States: IDLE, RD, WR, DONE.
- IDLE + start (legal): latch op, addr, wdata. Aligned full-width store -> WR; otherwise -> RD. start while busy is ignored; not queued.
- RD: mem_addr=aligned addr, mem_wr=0, counter runs 1..MEM_LAT; mem_rdata captured at the edge ending the MEM_LAT-th RD cycle. Load -> DONE with rdata_out loaded. Store -> WR with the merge word registered.
- Load extraction: select lane at OFF, replicate MSB (sign_ext=1) or zero-fill up to DATA_W.
- Store merge: replace only the addressed lane of the read word with wdata's low bytes; all other bytes preserved.
- WR: exactly one cycle with mem_wr=1, mem_addr aligned, mem_wdata=merged (or wdata for full-width). -> DONE.
- DONE: done=1 for one cycle; busy=1; -> IDLE. A start in DONE is ignored.
- Latency from accept edge (cycle 0): load done at cycle MEM_LAT+1; sub-word store at MEM_LAT+2 (mem_wr at MEM_LAT+1); full-width store at 2 (mem_wr at 1); misaligned at 1.
- rdata_out holds until the next successful load; stores never change it.
- Outside WR, mem_wr=0 and mem_wdata holds its last value.

Decomposition:
- Package mem_access_pkg: size encodings (SZ_B, SZ_H, SZ_W, SZ_D), state enum, and an offset-width function derived from DATA_W.
- Sub-module load_align_ext: combinational lane select + sign/zero extension (DATA_W, size, sign_ext, OFF), reused by the load path. The merge logic stays inline.

Test Plan:
- DATA_W=32, MEM_LAT=2, memory[0x100]=0x80FF7F01; LB sign_ext=1 addr 0x103 -> done at cycle 3, rdata_out=0xFFFFFF80, misalign=0, mem_wr never asserted.
- Same memory; LHU addr 0x102 -> done at cycle 3, rdata_out=0x000080FF; then LH addr 0x100 -> 0x00007F01.
- Memory[0x100]=0x11223344; SB addr 0x101 wdata 0x000000AB -> mem_wr exactly once at cycle 3, mem_addr 0x100, mem_wdata 0x1122AB44; done at cycle 4.
- SW addr 0x200 wdata 0xDEADBEEF -> no RD state; mem_wr at cycle 1 with mem_wdata 0xDEADBEEF; done at cycle 2. A start pulsed at cycle 1 is ignored.
- LH addr 0x101 -> done at cycle 1 with misalign=1, no memory access, rdata_out unchanged. Same result for size=11 at DATA_W=32.
- SH addr 0x102 with reset asserted at cycle 2 (during RD) -> cycle 3 all outputs 0, mem_wr never 1. A subsequent LW addr 0x100 completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store sequencer: access sizes, FSM states and
// the byte-offset width helper.
package mem_access_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StDone
  } state_e;

  // Number of byte-offset bits inside one memory word.
  function automatic int unsigned off_width(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Load lane select: shifts the addressed lane down to bit 0 and sign- or
// zero-extends it to the full data width.
module load_align_ext
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OW     = off_width(DATA_W)
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        size_i,
  input  logic              sign_ext_i,
  input  logic [OW-1:0]     off_i,
  output logic [DATA_W-1:0] result_o
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              msb;

  assign shifted = word_i >> {off_i, 3'b000};

  always_comb begin
    mask = '1;
    msb  = shifted[DATA_W-1];
    case (size_i)
      SZ_B: begin
        mask = DATA_W'(8'hFF);
        msb  = shifted[7];
      end
      SZ_H: begin
        mask = DATA_W'(16'hFFFF);
        msb  = shifted[15];
      end
      SZ_W: begin
        mask = DATA_W'(32'hFFFF_FFFF);
        msb  = shifted[31];
      end
      default: begin
        mask = '1;
        msb  = shifted[DATA_W-1];
      end
    endcase
  end

  // Bits above the lane take the replicated MSB only when sign-extending.
  assign result_o = (shifted & mask) | ({DATA_W{sign_ext_i & msb}} & ~mask);

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle load/store sequencer: aligned word fetch, lane extraction,
// read-modify-write for sub-word stores and misalignment rejection.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata_out,
  output logic              busy,
  output logic              done,
  output logic              misalign
);

  localparam int unsigned OW      = off_width(DATA_W);
  localparam int unsigned CNT_W   = $clog2(MEM_LAT + 1);
  localparam logic [1:0]  FULL_SZ = (DATA_W == 64) ? SZ_D : SZ_W;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_store_q, is_store_d;
  logic [1:0]        size_q, size_d;
  logic              sign_ext_q, sign_ext_d;
  logic [OW-1:0]     off_q, off_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_out_q, rdata_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              misalign_q, misalign_d;

  logic [OW-1:0]     req_off;
  logic              req_misalign;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] merged;
  logic [OW+2:0]     bit_off;

  assign req_off = addr[OW-1:0];

  always_comb begin
    case (size)
      SZ_B:    req_misalign = 1'b0;
      SZ_H:    req_misalign = req_off[0];
      SZ_W:    req_misalign = |req_off[1:0];
      default: req_misalign = (DATA_W != 64) || (|req_off);
    endcase
  end

  load_align_ext #(
    .DATA_W (DATA_W),
    .OW     (OW)
  ) u_load_align_ext (
    .word_i     (mem_rdata),
    .size_i     (size_q),
    .sign_ext_i (sign_ext_q),
    .off_i      (off_q),
    .result_o   (load_ext)
  );

  // Store merge: overwrite only the addressed lane of the fetched word.
  assign bit_off = {off_q, 3'b000};

  always_comb begin
    merged = mem_rdata;
    case (size_q)
      SZ_B:    merged[bit_off +: 8]  = wdata_q[7:0];
      SZ_H:    merged[bit_off +: 16] = wdata_q[15:0];
      SZ_W:    merged[bit_off +: 32] = wdata_q[31:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_store_d  = is_store_q;
    size_d      = size_q;
    sign_ext_d  = sign_ext_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wr_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    rdata_out_d = rdata_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    misalign_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          busy_d = 1'b1;
          if (req_misalign) begin
            state_d    = StDone;
            done_d     = 1'b1;
            misalign_d = 1'b1;
          end else begin
            is_store_d = is_store;
            size_d     = size;
            sign_ext_d = sign_ext;
            off_d      = req_off;
            wdata_d    = wdata;
            mem_addr_d = {addr[ADDR_W-1:OW], {OW{1'b0}}};
            if (is_store && (size == FULL_SZ)) begin
              state_d     = StWr;
              mem_wr_d    = 1'b1;
              mem_wdata_d = wdata;
            end else begin
              state_d = StRd;
              cnt_d   = CNT_W'(1);
            end
          end
        end
      end
      StRd: begin
        if (cnt_q == CNT_W'(MEM_LAT)) begin
          cnt_d = '0;
          if (is_store_q) begin
            state_d     = StWr;
            mem_wr_d    = 1'b1;
            mem_wdata_d = merged;
          end else begin
            state_d     = StDone;
            done_d      = 1'b1;
            rdata_out_d = load_ext;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StWr: begin
        state_d = StDone;
        done_d  = 1'b1;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      is_store_q  <= 1'b0;
      size_q      <= SZ_B;
      sign_ext_q  <= 1'b0;
      off_q       <= '0;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      rdata_out_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_store_q  <= is_store_d;
      size_q      <= size_d;
      sign_ext_q  <= sign_ext_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_out_q <= rdata_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata_out = rdata_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (DATA_W=32, MEM_LAT=2) against a small
// word-addressed memory model.
module tb_mem_access_unit;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned MEM_LAT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              is_store;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rdata_out;
  logic              busy;
  logic              done;
  logic              misalign;

  logic [31:0] mem [256];

  int n_checks = 0;
  int n_errors = 0;

  int          done_cyc;
  int          wr_cyc;
  int          wr_cnt;
  int          busy_gap;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] first_addr;
  logic        done_misalign;

  mem_access_unit #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .MEM_LAT (MEM_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_store  (is_store),
    .size      (size),
    .sign_ext  (sign_ext),
    .addr      (addr),
    .wdata     (wdata),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rdata_out (rdata_out),
    .busy      (busy),
    .done      (done),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  // Address is held for the whole RD phase, so an asynchronous read model
  // presents valid data well before the capturing edge.
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request; cycle 1 is the cycle right after the accept edge.
  task automatic run_op(input logic st, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input int poke_cyc);
    int cyc;
    @(posedge clk); #1;
    is_store = st;
    size     = sz;
    sign_ext = sx;
    addr     = a;
    wdata    = wd;
    start    = 1'b1;
    @(posedge clk); #1;
    start         = 1'b0;
    cyc           = 1;
    done_cyc      = -1;
    wr_cyc        = -1;
    wr_cnt        = 0;
    busy_gap      = 0;
    done_misalign = 1'b0;
    first_addr    = mem_addr;
    while (cyc <= 20) begin
      if (mem_wr) begin
        wr_cnt++;
        wr_cyc  = cyc;
        wr_addr = mem_addr;
        wr_data = mem_wdata;
      end
      if (!busy) busy_gap++;
      if (done) begin
        done_cyc      = cyc;
        done_misalign = misalign;
        break;
      end
      if (cyc == poke_cyc) begin
        // A full-width store that would be visible if it were wrongly accepted.
        is_store = 1'b1;
        size     = 2'b10;
        addr     = 32'h300;
        wdata    = 32'h5A5A_5A5A;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic load_case(input string tag, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] exp);
    run_op(1'b0, sz, sx, a, 32'h0, 0);
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'd3);
    check({tag, "_rdata"}, rdata_out, exp);
    check({tag, "_misalign"}, 32'(done_misalign), 32'd0);
    check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd0);
  endtask

  initial begin
    int extra_done;
    int extra_wr;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    reset    = 1'b1;
    start    = 1'b0;
    is_store = 1'b0;
    size     = 2'b00;
    sign_ext = 1'b0;
    addr     = 32'h0;
    wdata    = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_rdata_out", rdata_out, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_misalign", 32'(misalign), 32'h0);
    reset = 1'b0;

    // Loads from 0x80FF7F01
    mem[8'h40] = 32'h80FF_7F01;
    run_op(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0);
    check("lb103_done_cyc", 32'(done_cyc), 32'd3);
    check("lb103_rdata", rdata_out, 32'hFFFF_FF80);
    check("lb103_misalign", 32'(done_misalign), 32'd0);
    check("lb103_wr_cnt", 32'(wr_cnt), 32'd0);
    check("lb103_mem_addr", first_addr, 32'h100);
    check("lb103_busy_gap", 32'(busy_gap), 32'd0);
    load_case("lhu102", 2'b01, 1'b0, 32'h102, 32'h0000_80FF);
    load_case("lh100", 2'b01, 1'b1, 32'h100, 32'h0000_7F01);
    load_case("lh102", 2'b01, 1'b1, 32'h102, 32'hFFFF_80FF);
    load_case("lbu102", 2'b00, 1'b0, 32'h102, 32'h0000_00FF);
    load_case("lb101", 2'b00, 1'b1, 32'h101, 32'h0000_007F);
    load_case("lw100", 2'b10, 1'b1, 32'h100, 32'h80FF_7F01);

    // Sub-word stores via read-modify-write
    mem[8'h40] = 32'h1122_3344;
    run_op(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_00AB, 0);
    check("sb101_wr_cnt", 32'(wr_cnt), 32'd1);
    check("sb101_wr_cyc", 32'(wr_cyc), 32'd3);
    check("sb101_wr_addr", wr_addr, 32'h100);
    check("sb101_wr_data", wr_data, 32'h1122_AB44);
    check("sb101_done_cyc", 32'(done_cyc), 32'd4);
    check("sb101_rdata_kept", rdata_out, 32'h80FF_7F01);
    check("sb101_mem", mem[8'h40], 32'h1122_AB44);
    run_op(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234_CAFE, 0);
    check("sh102_wr_data", wr_data, 32'hCAFE_AB44);
    check("sh102_done_cyc", 32'(done_cyc), 32'd4);

    // Full-width store skips RD; start during WR must be dropped
    run_op(1'b1, 2'b10, 1'b0, 32'h200, 32'hDEAD_BEEF, 1);
    check("sw200_wr_cyc", 32'(wr_cyc), 32'd1);
    check("sw200_wr_cnt", 32'(wr_cnt), 32'd1);
    check("sw200_wr_addr", wr_addr, 32'h200);
    check("sw200_wr_data", wr_data, 32'hDEAD_BEEF);
    check("sw200_done_cyc", 32'(done_cyc), 32'd2);
    extra_done = 0;
    extra_wr   = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) extra_done++;
      if (mem_wr) extra_wr++;
    end
    check("sw200_no_queue_done", 32'(extra_done), 32'd0);
    check("sw200_no_queue_wr", 32'(extra_wr), 32'd0);
    check("sw200_idle_busy", 32'(busy), 32'd0);
    check("sw200_mem300", mem[8'hC0], 32'h0);

    // Misaligned requests
    run_op(1'b0, 2'b01, 1'b1, 32'h101, 32'h0, 0);
    check("lh101_done_cyc", 32'(done_cyc), 32'd1);
    check("lh101_misalign", 32'(done_misalign), 32'd1);
    check("lh101_wr_cnt", 32'(wr_cnt), 32'd0);
    check("lh101_rdata_kept", rdata_out, 32'h80FF_7F01);
    check("lh101_mem_addr_kept", first_addr, 32'h200);
    run_op(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 0);
    check("ld32_done_cyc", 32'(done_cyc), 32'd1);
    check("ld32_misalign", 32'(done_misalign), 32'd1);
    check("ld32_rdata_kept", rdata_out, 32'h80FF_7F01);
    run_op(1'b1, 2'b10, 1'b0, 32'h102, 32'h1111_1111, 0);
    check("sw102_misalign", 32'(done_misalign), 32'd1);
    check("sw102_wr_cnt", 32'(wr_cnt), 32'd0);

    // Reset during RD of a sub-word store
    @(posedge clk); #1;
    is_store = 1'b1;
    size     = 2'b01;
    sign_ext = 1'b0;
    addr     = 32'h102;
    wdata    = 32'h0000_5555;
    start    = 1'b1;
    extra_wr = 0;
    @(posedge clk); #1;
    start = 1'b0;
    if (mem_wr) extra_wr++;
    @(posedge clk); #1;
    if (mem_wr) extra_wr++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rrd_mem_addr", mem_addr, 32'h0);
    check("rrd_mem_wr", 32'(mem_wr), 32'h0);
    check("rrd_mem_wdata", mem_wdata, 32'h0);
    check("rrd_rdata_out", rdata_out, 32'h0);
    check("rrd_busy", 32'(busy), 32'h0);
    check("rrd_done", 32'(done), 32'h0);
    check("rrd_misalign", 32'(misalign), 32'h0);
    repeat (4) begin
      @(posedge clk); #1;
      if (mem_wr) extra_wr++;
    end
    check("rrd_no_wr", 32'(extra_wr), 32'd0);
    check("rrd_mem_kept", mem[8'h40], 32'hCAFE_AB44);
    load_case("lw_after_rst", 2'b10, 1'b0, 32'h100, 32'hCAFE_AB44);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
